regsr_shifter: RTL and testbench
================================

REGSR_SHIFTER -- requirements
Module: regsr_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning register width in bits (legal range 2..64).
REQ-002 SHALL have derived parameter AMTW, default clog2(WIDTH)+1, meaning shift-amount width.
REQ-003 SHALL have port C  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port R  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port S  input  1  synchronous set, active-high: Q to all-ones.
REQ-006 SHALL have port start  input  1  operation request, sampled in IDLE only.
REQ-007 SHALL have port op  input  3  operation code, sampled with start.
REQ-008 SHALL have port amt  input  AMTW  shift count, sampled with start.
REQ-009 SHALL have port D  input  WIDTH  parallel load data.
REQ-010 SHALL have port sin  input  1  serial fill bit, sampled live on every shift edge.
REQ-011 SHALL have port Q  output  WIDTH  register contents.
REQ-012 SHALL have port sout  output  1  registered copy of the bit most recently shifted or rotated out.
REQ-013 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL use op encoding: 000 NOP, 001 LOAD, 010 SHL (sin into LSB), 011 SHR (sin into MSB), 100 ROTL, 101 ROTR, 110 ASR (MSB replicated), 111 reserved, treated as NOP.
REQ-016 SHALL implement states IDLE, SHIFT, DONE.
REQ-017 IDLE + start + LOAD: Q<=D on that edge; next state DONE.
REQ-018 IDLE + start + NOP/reserved: Q unchanged; next state DONE.
REQ-019 IDLE + start + shift/rotate op, amt=0: Q unchanged; next state DONE.
REQ-020 IDLE + start + shift/rotate op, amt=N>0: latch op; set counter=N; next state SHIFT; Q unchanged on the accept edge.
REQ-021 SHIFT: each edge applies exactly one 1-bit step of the latched op to Q, loads sout with the exiting bit, and decrements the counter.
REQ-022 SHIFT: counter reaching 0 SHALL cause transition to DONE; Q receives exactly N steps.
REQ-023 amt values above WIDTH SHALL be executed literally: rotates wrap modulo WIDTH; shifts fully flush with fill bits.
REQ-024 DONE SHALL last exactly one cycle, with done=1 and busy=1, then return to IDLE; Q holds the final result.
REQ-025 start outside IDLE SHALL be ignored, with no queuing.
REQ-026 sout SHALL change only on SHIFT edges, and SHALL hold otherwise, including across LOAD.
REQ-027 S, when asserted without R in any state: Q<=all-ones; state<=IDLE; operation aborted, no done pulse; sout unchanged.
REQ-028 S and start together in IDLE: S wins and start is dropped.
REQ-029 Latency: LOAD/NOP/amt=0 gives done 1 cycle after accept; amt=N gives done N+1 cycles after accept.

Reset
REQ-030 R SHALL have priority over S and over all other inputs.
REQ-031 R SHALL set Q=0, sout=0, state=IDLE, counter=0, busy=0, done=0 on the next rising edge of C.
REQ-032 R mid-operation SHALL abort immediately, with no done pulse.

Structure
REQ-033 Op encodings, state encoding and the AMTW function SHALL reside in a shared package, regsr_pkg.
REQ-034 A single combinational sub-module, shift_step, SHALL compute the one-step next Q and the exiting bit from (Q, op, sin).
REQ-035 The control FSM, counter and storage SHALL reside in regsr_shifter; target size is 120-400 lines total.

Verification (WIDTH=8)
REQ-036 R high 1 cycle with S high -> Q=0x00, sout=0, busy=0, done=0.
REQ-037 LOAD D=0x81, then ROTL amt=3 -> done on cycle 4 after accept, Q=0x0C, sout=0.
REQ-038 Q=0x0F, SHR amt=4, sin=1 -> Q=0xF0, sout=1; Q=0x80, ASR amt=2 -> Q=0xE0.
REQ-039 SHL amt=9 on Q=0xFF with sin=0 -> Q=0x00, done 10 cycles after accept; start pulsed while busy -> no effect.
REQ-040 S asserted on 2nd SHIFT cycle of ROTR amt=5 -> Q=0xFF, next cycle busy=0, done never pulses; R mid-SHIFT -> Q=0x00, IDLE.
REQ-041 amt=0 ROTL and op=111 -> Q unchanged, done pulse exactly 1 cycle after accept.

Source files
------------

// File: rtl/regsr_pkg.sv
// Shared definitions for the serial shift/rotate register: op codes, FSM states
// and the shift-amount width rule.
package regsr_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_SHL  = 3'b010,
        OP_SHR  = 3'b011,
        OP_ROTL = 3'b100,
        OP_ROTR = 3'b101,
        OP_ASR  = 3'b110,
        OP_RSV  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // One extra bit so a count equal to WIDTH (or beyond) is representable.
    function automatic int amt_w(input int w);
        return $clog2(w) + 1;
    endfunction

    function automatic logic is_shift_op(input op_e op);
        return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROTL) ||
               (op == OP_ROTR) || (op == OP_ASR);
    endfunction

endpackage

// File: rtl/regsr_shifter_shift_step.sv
// Combinational single-step shifter: next register value and the bit leaving it.
module shift_step
    import regsr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_q,
    input  op_e              i_op,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q_next,
    output logic             o_bit_out
);

    always_comb begin
        o_q_next  = i_q;
        o_bit_out = 1'b0;
        case (i_op)
            OP_SHL: begin
                o_q_next  = {i_q[WIDTH-2:0], i_sin};
                o_bit_out = i_q[WIDTH-1];
            end
            OP_SHR: begin
                o_q_next  = {i_sin, i_q[WIDTH-1:1]};
                o_bit_out = i_q[0];
            end
            OP_ROTL: begin
                o_q_next  = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_bit_out = i_q[WIDTH-1];
            end
            OP_ROTR: begin
                o_q_next  = {i_q[0], i_q[WIDTH-1:1]};
                o_bit_out = i_q[0];
            end
            OP_ASR: begin
                o_q_next  = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
                o_bit_out = i_q[0];
            end
            default: begin
                o_q_next  = i_q;
                o_bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/regsr_shifter.sv
// Multi-cycle shift/rotate register: one bit per clock under a small FSM,
// with parallel load, synchronous set and synchronous reset.
module regsr_shifter
    import regsr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMTW  = amt_w(WIDTH)
) (
    input  logic             C,
    input  logic             R,
    input  logic             S,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AMTW-1:0]  amt,
    input  logic [WIDTH-1:0] D,
    input  logic             sin,
    output logic [WIDTH-1:0] Q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    logic [WIDTH-1:0] r_q;
    logic             r_sout;
    logic [AMTW-1:0]  r_cnt;
    op_e              r_op;
    state_e           r_state;

    op_e              w_op;
    logic [WIDTH-1:0] w_q_next;
    logic             w_bit_out;

    assign w_op = op_e'(op);

    shift_step #(.WIDTH(WIDTH)) u_step (
        .i_q       (r_q),
        .i_op      (r_op),
        .i_sin     (sin),
        .o_q_next  (w_q_next),
        .o_bit_out (w_bit_out)
    );

    always_ff @(posedge C) begin
        if (R) begin
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_cnt   <= '0;
            r_op    <= OP_NOP;
            r_state <= ST_IDLE;
        end else if (S) begin
            // Set aborts any operation silently; sout keeps its last value.
            r_q     <= '1;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (w_op == OP_LOAD) begin
                            r_q     <= D;
                            r_state <= ST_DONE;
                        end else if (is_shift_op(w_op) && (amt != '0)) begin
                            r_op    <= w_op;
                            r_cnt   <= amt;
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_q    <= w_q_next;
                    r_sout <= w_bit_out;
                    r_cnt  <= r_cnt - AMTW'(1);
                    if (r_cnt == AMTW'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Q    = r_q;
    assign sout = r_sout;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_regsr_shifter.sv
// Scoreboard bench for regsr_shifter at WIDTH=8: directed operations queue their
// expected result and done cycle; a monitor checks each done pulse against the queue.
module tb_regsr_shifter;

    localparam int WIDTH = 8;
    localparam int AMTW  = 4;

    logic             C = 1'b0;
    logic             R;
    logic             S;
    logic             start;
    logic [2:0]       op;
    logic [AMTW-1:0]  amt;
    logic [WIDTH-1:0] D;
    logic             sin;
    logic [WIDTH-1:0] Q;
    logic             sout;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             s;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_bad  = 0;
    int   n_done = 0;
    int   cyc    = 0;

    regsr_shifter #(.WIDTH(WIDTH), .AMTW(AMTW)) dut (
        .C     (C),
        .R     (R),
        .S     (S),
        .start (start),
        .op    (op),
        .amt   (amt),
        .D     (D),
        .sin   (sin),
        .Q     (Q),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 C = ~C;

    always @(posedge C) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge C) begin
        if (done === 1'b1) begin
            exp_t e;
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no pulse", cyc);
            end else begin
                e = sb.pop_front();
                chk("done_q",    64'(Q),    64'(e.q));
                chk("done_sout", 64'(sout), 64'(e.s));
                chk("done_cyc",  64'(cyc),  64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] o, input int a, input logic [WIDTH-1:0] d,
                         input logic push, input logic [WIDTH-1:0] eq, input logic es,
                         input int lat);
        op    = o;
        amt   = AMTW'(a);
        D     = d;
        start = 1'b1;
        if (push) sb.push_back('{eq, es, cyc + 1 + lat});
        @(negedge C);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((busy !== 1'b0 || done !== 1'b0) && k < 40) begin
            @(negedge C);
            k++;
        end
        chk("idle_timeout", 64'(k < 40), 64'(1));
    endtask

    task automatic run(input logic [2:0] o, input int a, input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] eq, input logic es, input int lat);
        issue(o, a, d, 1'b1, eq, es, lat);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nd0;
        R = 1'b1; S = 1'b1; start = 1'b0; op = 3'b000; amt = '0; D = '0; sin = 1'b0;
        @(negedge C);
        R = 1'b0; S = 1'b0;
        chk("rst_q",    64'(Q),    64'h00);
        chk("rst_sout", 64'(sout), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);

        // LOAD then ROTL 3
        run(3'b001, 0, 8'h81, 8'h81, 1'b0, 0);
        run(3'b100, 3, 8'h00, 8'h0C, 1'b0, 3);

        // SHR with sin=1, then LOAD keeps sout, then ASR
        run(3'b001, 0, 8'h0F, 8'h0F, 1'b0, 0);
        sin = 1'b1;
        run(3'b011, 4, 8'h00, 8'hF0, 1'b1, 4);
        sin = 1'b0;
        run(3'b001, 0, 8'h80, 8'h80, 1'b1, 0);
        run(3'b110, 2, 8'h00, 8'hE0, 1'b0, 2);

        // SHL 9 flushes fully; start pulsed mid-operation is ignored
        run(3'b001, 0, 8'hFF, 8'hFF, 1'b0, 0);
        issue(3'b010, 9, 8'h00, 1'b1, 8'h00, 1'b0, 9);
        repeat (3) @(negedge C);
        op = 3'b001; D = 8'h55; start = 1'b1;
        @(negedge C);
        start = 1'b0;
        wait_idle();

        // amt=0 rotate, reserved op and NOP leave Q alone
        run(3'b001, 0, 8'h3C, 8'h3C, 1'b0, 0);
        run(3'b100, 0, 8'h00, 8'h3C, 1'b0, 0);
        run(3'b111, 3, 8'h00, 8'h3C, 1'b0, 0);
        run(3'b000, 2, 8'h00, 8'h3C, 1'b0, 0);

        // Set during the 2nd SHIFT cycle of ROTR 5
        nd0 = n_done;
        issue(3'b101, 5, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        @(negedge C);
        chk("rotr_step1_q", 64'(Q), 64'h1E);
        S = 1'b1;
        @(negedge C);
        S = 1'b0;
        chk("set_abort_q",    64'(Q),    64'hFF);
        chk("set_abort_busy", 64'(busy), 64'h0);
        repeat (8) @(negedge C);
        chk("set_abort_nodone", 64'(n_done), 64'(nd0));

        // Set together with start in IDLE: set wins
        run(3'b001, 0, 8'h12, 8'h12, 1'b0, 0);
        nd0 = n_done;
        S = 1'b1; op = 3'b001; D = 8'h34; start = 1'b1;
        @(negedge C);
        S = 1'b0; start = 1'b0;
        chk("set_start_q",    64'(Q),    64'hFF);
        chk("set_start_busy", 64'(busy), 64'h0);
        repeat (4) @(negedge C);
        chk("set_start_nodone", 64'(n_done), 64'(nd0));

        // Reset in the middle of SHL 5
        run(3'b001, 0, 8'hA5, 8'hA5, 1'b0, 0);
        nd0 = n_done;
        issue(3'b010, 5, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        @(negedge C);
        chk("shl_step1_q",    64'(Q),    64'h4A);
        chk("shl_step1_sout", 64'(sout), 64'h1);
        R = 1'b1;
        @(negedge C);
        R = 1'b0;
        chk("rst_mid_q",    64'(Q),    64'h00);
        chk("rst_mid_sout", 64'(sout), 64'h0);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        repeat (8) @(negedge C);
        chk("rst_mid_nodone", 64'(n_done), 64'(nd0));

        // Rotate beyond WIDTH wraps
        run(3'b001, 0, 8'h81, 8'h81, 1'b0, 0);
        run(3'b100, 10, 8'h00, 8'h06, 1'b0, 10);

        repeat (3) @(negedge C);
        chk("sb_drain", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
